// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, ALU codes,
// opcode/func values and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StImmEx   = 4'd8,
    StImmWb   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJr      = 4'd12,
    StJal     = 4'd13,
    StIllegal = 4'd14
  } state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluLui = 4'b1111;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcReg    = 2'd3;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] MemToRegAlu = 2'd0;
  localparam logic [1:0] MemToRegMdr = 2'd1;
  localparam logic [1:0] MemToRegPc  = 2'd2;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrIllegal = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

endpackage

// File: rtl/mips_alu_decode.sv
// Maps opcode/func to the ALU operation and immediate extension mode.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic [3:0] alu_cntrl_o,
  output logic       ext_cntrl_o
);

  always_comb begin
    alu_cntrl_o = AluAdd;
    ext_cntrl_o = 1'b1;
    case (op_i)
      OpRtype: begin
        case (func_i)
          FnSub:   alu_cntrl_o = AluSub;
          FnSlt:   alu_cntrl_o = AluSlt;
          FnNor:   alu_cntrl_o = AluNor;
          default: alu_cntrl_o = AluAdd;
        endcase
      end
      OpAndi: begin
        alu_cntrl_o = AluAnd;
        ext_cntrl_o = 1'b0;
      end
      OpLui: begin
        alu_cntrl_o = AluLui;
        ext_cntrl_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and latches illegal-instruction and memory-timeout faults.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W    = 16,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [5:0]         op_in,
  input  logic [5:0]         func_in,
  input  logic               zero_in,
  input  logic               mem_ready_in,
  output logic               pcEn_out,
  output logic [1:0]         pcSource_out,
  output logic               iorD_out,
  output logic               memRead_out,
  output logic               memWrite_out,
  output logic               irWrite_out,
  output logic [1:0]         regDst_out,
  output logic [1:0]         memToReg_out,
  output logic               regWrite_out,
  output logic               ALUSrcA_out,
  output logic [1:0]         ALUSrcB_out,
  output logic [3:0]         ALUCntrl_out,
  output logic               extCntrl_out,
  output logic [3:0]         state_out,
  output logic [COUNT_W-1:0] instr_count_out,
  output logic [1:0]         err_out
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         err_q, err_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [3:0]         alu_dec;
  logic               ext_dec;

  mips_alu_decode u_alu_decode (
    .op_i        (op_in),
    .func_i      (func_in),
    .alu_cntrl_o (alu_dec),
    .ext_cntrl_o (ext_dec)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wait_d  = '0;
    case (state_q)
      StFetch:  if (mem_ready_in) state_d = StDecode;
      StDecode: begin
        case (op_in)
          OpLw, OpSw:            state_d = StMemAdr;
          OpAddi, OpAndi, OpLui: state_d = StImmEx;
          OpBeq, OpBne:          state_d = StBranch;
          OpJ:                   state_d = StJump;
          OpJal:                 state_d = StJal;
          OpRtype: begin
            case (func_in)
              FnSll:                     state_d = StFetch;
              FnJr:                      state_d = StJr;
              FnAdd, FnSub, FnSlt, FnNor: state_d = StRtypeEx;
              default:                   state_d = StIllegal;
            endcase
          end
          default: state_d = StIllegal;
        endcase
        if (state_d == StIllegal) err_d = ErrIllegal;
      end
      StMemAdr:  state_d = (op_in == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready_in) state_d = StMemWb;
      StMemWr:   if (mem_ready_in) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StImmEx:   state_d = StImmWb;
      StIllegal: state_d = StIllegal;
      default:   state_d = StFetch;
    endcase

    // Ready in the limit cycle never reaches here, so ready wins over timeout.
    if ((state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready_in) begin
      if (wait_q == WaitW'(WAIT_LIMIT - 1)) begin
        state_d = StIllegal;
        err_d   = ErrTimeout;
      end else begin
        wait_d = wait_q + WaitW'(1);
      end
    end

    count_d = count_q;
    if (state_d == StFetch && state_q != StFetch) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StFetch;
      count_q <= '0;
      err_q   <= ErrNone;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    pcEn_out     = 1'b0;
    pcSource_out = PcSrcAlu;
    iorD_out     = 1'b0;
    memRead_out  = 1'b0;
    memWrite_out = 1'b0;
    irWrite_out  = 1'b0;
    regDst_out   = RegDstRt;
    memToReg_out = MemToRegAlu;
    regWrite_out = 1'b0;
    ALUSrcA_out  = 1'b0;
    ALUSrcB_out  = SrcBReg;
    ALUCntrl_out = AluAdd;
    extCntrl_out = 1'b0;
    case (state_q)
      StFetch: begin
        memRead_out = 1'b1;
        ALUSrcB_out = SrcBFour;
        irWrite_out = mem_ready_in;
        pcEn_out    = mem_ready_in;
      end
      StDecode: begin
        ALUSrcB_out  = SrcBImmSh;
        extCntrl_out = 1'b1;
      end
      StMemAdr: begin
        ALUSrcA_out  = 1'b1;
        ALUSrcB_out  = SrcBImm;
        extCntrl_out = 1'b1;
      end
      StMemRd: begin
        memRead_out = 1'b1;
        iorD_out    = 1'b1;
      end
      StMemWb: begin
        memToReg_out = MemToRegMdr;
        regWrite_out = 1'b1;
      end
      StMemWr: begin
        memWrite_out = 1'b1;
        iorD_out     = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA_out  = 1'b1;
        ALUCntrl_out = alu_dec;
      end
      StRtypeWb: begin
        regDst_out   = RegDstRd;
        regWrite_out = 1'b1;
      end
      StImmEx: begin
        ALUSrcA_out  = 1'b1;
        ALUSrcB_out  = SrcBImm;
        ALUCntrl_out = alu_dec;
        extCntrl_out = ext_dec;
      end
      StImmWb: regWrite_out = 1'b1;
      StBranch: begin
        ALUSrcA_out  = 1'b1;
        ALUCntrl_out = AluSub;
        pcSource_out = PcSrcAluOut;
        pcEn_out     = ((op_in == OpBeq) && zero_in) || ((op_in == OpBne) && !zero_in);
      end
      StJump: begin
        pcSource_out = PcSrcJump;
        pcEn_out     = 1'b1;
      end
      StJr: begin
        pcSource_out = PcSrcReg;
        pcEn_out     = 1'b1;
      end
      StJal: begin
        pcSource_out = PcSrcJump;
        pcEn_out     = 1'b1;
        regDst_out   = RegDstRa;
        memToReg_out = MemToRegPc;
        regWrite_out = 1'b1;
      end
      default: ;
    endcase

    if (!rst_n_in) begin
      pcEn_out     = 1'b0;
      memRead_out  = 1'b0;
      memWrite_out = 1'b0;
      irWrite_out  = 1'b0;
      regWrite_out = 1'b0;
    end
  end

  assign state_out       = state_q;
  assign instr_count_out = count_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multi-cycle control FSM: stimulus queues the expected
// control word per cycle, a negedge monitor pops and compares.
module tb_mips_multicycle_control;

  localparam logic [3:0] SFetch = 4'd0,  SDecode = 4'd1,  SMemAdr = 4'd2,  SMemRd = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4,  SMemWr = 4'd5,   SRtEx = 4'd6,    SRtWb = 4'd7;
  localparam logic [3:0] SImmEx = 4'd8,  SImmWb = 4'd9,   SBranch = 4'd10, SJump = 4'd11;
  localparam logic [3:0] SJr = 4'd12,    SJal = 4'd13,    SIll = 4'd14;

  logic       clk_in;
  logic       rst_n_in;
  logic [5:0] op_in, func_in;
  logic       zero_in, mem_ready_in;
  logic       pcEn_out, iorD_out, memRead_out, memWrite_out, irWrite_out, regWrite_out;
  logic       ALUSrcA_out, extCntrl_out;
  logic [1:0] pcSource_out, regDst_out, memToReg_out, ALUSrcB_out, err_out;
  logic [3:0] ALUCntrl_out, state_out;
  logic [1:0] instr_count_out;

  mips_multicycle_control #(.COUNT_W(2), .WAIT_LIMIT(4)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .op_in           (op_in),
    .func_in         (func_in),
    .zero_in         (zero_in),
    .mem_ready_in    (mem_ready_in),
    .pcEn_out        (pcEn_out),
    .pcSource_out    (pcSource_out),
    .iorD_out        (iorD_out),
    .memRead_out     (memRead_out),
    .memWrite_out    (memWrite_out),
    .irWrite_out     (irWrite_out),
    .regDst_out      (regDst_out),
    .memToReg_out    (memToReg_out),
    .regWrite_out    (regWrite_out),
    .ALUSrcA_out     (ALUSrcA_out),
    .ALUSrcB_out     (ALUSrcB_out),
    .ALUCntrl_out    (ALUCntrl_out),
    .extCntrl_out    (extCntrl_out),
    .state_out       (state_out),
    .instr_count_out (instr_count_out),
    .err_out         (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord, mrd, mwr, irw;
    logic [1:0] rdst, m2r;
    logic       rw, srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic       ext;
    logic [1:0] cnt, err;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  w;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         passed = 0;
  logic [1:0] exp_cnt;
  logic [1:0] exp_err;

  // Static control word per state; input-dependent fields are patched by cyc().
  function automatic ctl_t base(input logic [3:0] st);
    ctl_t c = '0;
    c.st  = st;
    c.alu = 4'b0010;
    case (st)
      SFetch:  begin c.mrd = 1'b1; c.srcb = 2'd1; end
      SDecode: begin c.srcb = 2'd3; c.ext = 1'b1; end
      SMemAdr: begin c.srca = 1'b1; c.srcb = 2'd2; c.ext = 1'b1; end
      SMemRd:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      SMemWb:  begin c.m2r = 2'd1; c.rw = 1'b1; end
      SMemWr:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      SRtEx:   c.srca = 1'b1;
      SRtWb:   begin c.rdst = 2'd1; c.rw = 1'b1; end
      SImmEx:  begin c.srca = 1'b1; c.srcb = 2'd2; end
      SImmWb:  c.rw = 1'b1;
      SBranch: begin c.srca = 1'b1; c.alu = 4'b0110; c.pc_src = 2'd1; end
      SJump:   begin c.pc_src = 2'd2; c.pc_en = 1'b1; end
      SJr:     begin c.pc_src = 2'd3; c.pc_en = 1'b1; end
      SJal:    begin c.pc_src = 2'd2; c.pc_en = 1'b1; c.rdst = 2'd2; c.m2r = 2'd2; c.rw = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(input string nm, input logic [3:0] st, input logic rdy, input logic z,
                     input logic pcen, input logic [3:0] alu, input logic ext);
    item_t it;
    it.name = nm;
    it.w    = base(st);
    if (st == SFetch) begin it.w.irw = rdy; it.w.pc_en = rdy; end
    if (st == SBranch) it.w.pc_en = pcen;
    if (st == SRtEx || st == SImmEx) begin it.w.alu = alu; it.w.ext = ext; end
    it.w.cnt = exp_cnt;
    it.w.err = exp_err;
    mem_ready_in = rdy;
    zero_in      = z;
    sb.push_back(it);
    @(posedge clk_in);
    #1;
  endtask

  task automatic c1(input string nm, input logic [3:0] st);
    cyc(nm, st, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
  endtask

  task automatic fd(input string nm, input logic [5:0] op, input logic [5:0] fn);
    op_in   = op;
    func_in = fn;
    c1({nm, "_fetch"}, SFetch);
    c1({nm, "_decode"}, SDecode);
  endtask

  task automatic retire();
    exp_cnt = exp_cnt + 2'd1;
  endtask

  // Reset asserted mid-cycle; the monitor checks at the following negedge.
  task automatic do_reset(input string nm);
    item_t it;
    #2;
    rst_n_in     = 1'b0;
    mem_ready_in = 1'b1;
    exp_cnt      = 2'd0;
    exp_err      = 2'd0;
    it.name      = nm;
    it.w         = base(SFetch);
    it.w.mrd     = 1'b0;
    sb.push_back(it);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  always @(negedge clk_in) begin : monitor
    ctl_t  act;
    item_t it;
    if (sb.size() > 0) begin
      it  = sb.pop_front();
      act = {state_out, pcEn_out, pcSource_out, iorD_out, memRead_out, memWrite_out,
             irWrite_out, regDst_out, memToReg_out, regWrite_out, ALUSrcA_out, ALUSrcB_out,
             ALUCntrl_out, extCntrl_out, instr_count_out, err_out};
      checks++;
      if (act === it.w) passed++;
      else $display("FAIL %s: state %0d got %b required %b", it.name, it.w.st, act, it.w);
    end
  end

  initial begin
    item_t it;
    rst_n_in     = 1'b0;
    op_in        = 6'h08;
    func_in      = 6'h00;
    zero_in      = 1'b0;
    mem_ready_in = 1'b1;
    exp_cnt      = 2'd0;
    exp_err      = 2'd0;
    it.name      = "reset";
    it.w         = base(SFetch);
    it.w.mrd     = 1'b0;
    sb.push_back(it);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    fd("addi", 6'h08, 6'h00);
    cyc("addi_ex", SImmEx, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    c1("addi_wb", SImmWb);
    retire();

    fd("lw", 6'h23, 6'h00);
    c1("lw_adr", SMemAdr);
    repeat (3) cyc("lw_rd_wait", SMemRd, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    c1("lw_rd_ready", SMemRd);
    c1("lw_wb", SMemWb);
    retire();

    fd("beq_z1", 6'h04, 6'h00);
    cyc("beq_z1_br", SBranch, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0);
    retire();
    fd("bne_z1", 6'h05, 6'h00);
    cyc("bne_z1_br", SBranch, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0);
    retire();
    fd("bne_z0", 6'h05, 6'h00);
    cyc("bne_z0_br", SBranch, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0);
    retire();

    fd("jal", 6'h03, 6'h00);
    c1("jal_st", SJal);
    retire();
    fd("jr", 6'h00, 6'h08);
    c1("jr_st", SJr);
    retire();
    fd("j", 6'h02, 6'h00);
    c1("j_st", SJump);
    retire();

    fd("sw", 6'h2b, 6'h00);
    c1("sw_adr", SMemAdr);
    c1("sw_wr", SMemWr);
    retire();

    fd("sub", 6'h00, 6'h22);
    cyc("sub_ex", SRtEx, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0);
    c1("sub_wb", SRtWb);
    retire();
    fd("nor", 6'h00, 6'h27);
    cyc("nor_ex", SRtEx, 1'b1, 1'b0, 1'b0, 4'b1100, 1'b0);
    c1("nor_wb", SRtWb);
    retire();
    fd("slt", 6'h00, 6'h2a);
    cyc("slt_ex", SRtEx, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0);
    c1("slt_wb", SRtWb);
    retire();
    fd("andi", 6'h0c, 6'h00);
    cyc("andi_ex", SImmEx, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    c1("andi_wb", SImmWb);
    retire();
    fd("lui", 6'h0f, 6'h00);
    cyc("lui_ex", SImmEx, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0);
    c1("lui_wb", SImmWb);
    retire();

    for (int i = 0; i < 5; i++) begin
      fd("nop", 6'h00, 6'h00);
      retire();
    end

    // Three misses then ready on the limit cycle: fetch proceeds.
    op_in   = 6'h00;
    func_in = 6'h00;
    repeat (3) cyc("fetch_wait", SFetch, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    c1("fetch_ready_at_limit", SFetch);
    c1("nop2_decode", SDecode);
    retire();

    // Reset during a load abandons it.
    fd("lw_abort", 6'h23, 6'h00);
    c1("lw_abort_adr", SMemAdr);
    cyc("lw_abort_rd", SMemRd, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    do_reset("reset_mid_lw");

    fd("illegal", 6'h3f, 6'h00);
    exp_err = 2'd1;
    for (int i = 0; i < 21; i++) c1("illegal_hold", SIll);
    do_reset("reset_from_illegal");

    repeat (4) cyc("fetch_timeout", SFetch, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    exp_err = 2'd2;
    repeat (3) c1("timeout_hold", SIll);
    do_reset("reset_from_timeout");

    fd("after_reset", 6'h08, 6'h00);
    cyc("after_reset_ex", SImmEx, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);

    repeat (2) @(posedge clk_in);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS core. It replaces the single-cycle decoder with a state machine that steps one shared ALU, a unified instruction/data memory port, and the register file through fetch, decode, execute, memory and writeback.
- Supported instructions: add, sub, slt, nor, jr, sll-as-nop, addi, andi, lui, lw, sw, beq, bne, j, jal.
- It sits between the instruction register/zero flag and the datapath muxes and enables.
- It counts retired instructions and latches fault status.

Parameters:
- COUNT_W, 16, width of retired-instruction counter (wraps).
- WAIT_LIMIT, 255, max consecutive cycles a memory state waits for mem_ready_in before a timeout fault.

Ports:
- clk_in  input  1  the single clock; all state changes on its rising edge.
- rst_n_in  input  1  reset, asynchronous and active-low.
- op_in  input  6  IR opcode.
- func_in  input  6  IR func field.
- zero_in  input  1  ALU zero flag.
- mem_ready_in  input  1  memory completes the current access this cycle.
- pcEn_out  output  1  PC load enable.
- pcSource_out  output  2  PC mux select: 0 ALU result, 1 ALUOut, 2 jump target, 3 R[rs].
- iorD_out  output  1  memory address select: 0 PC, 1 ALUOut.
- memRead_out  output  1  memory read strobe.
- memWrite_out  output  1  memory write strobe.
- irWrite_out  output  1  IR load enable.
- regDst_out  output  2  write register select: 0 rt, 1 rd, 2 $ra.
- memToReg_out  output  2  write data select: 0 ALUOut, 1 MDR, 2 PC.
- regWrite_out  output  1  register file write enable.
- ALUSrcA_out  output  1  ALU A select: 0 PC, 1 A register.
- ALUSrcB_out  output  2  ALU B select: 0 B, 1 constant 4, 2 ext(imm), 3 ext(imm)<<2.
- ALUCntrl_out  output  4  ALU operation code.
- extCntrl_out  output  1  immediate extension: 1 sign, 0 zero.
- state_out  output  4  current state encoding.
- instr_count_out  output  COUNT_W  retired-instruction count.
- err_out  output  2  fault code: 0 none, 1 illegal instruction, 2 memory timeout.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - state=FETCH(0), instr_count_out=0, err_out=0, wait counter=0.
  - While in reset, pcEn, memRead, memWrite, irWrite and regWrite are forced 0.
  - Reset mid-instruction abandons the instruction with no write.
- ALU codes: add 0010, sub 0110, and 0000, slt 0111, nor 1100, lui 1111.
- Unlisted outputs are 0 in every state. The default ALU code is add.
- States:
  - FETCH(0): memRead=1, iorD=0, SrcA=0, SrcB=1, add, pcSource=0. irWrite and pcEn equal mem_ready_in. Go to DECODE when ready, else stay.
  - DECODE(1): SrcA=0, SrcB=3, ext=1, add (branch target into ALUOut). Next state:
    - lw/sw go to MEMADR.
    - R-type add, sub, slt, nor go to RTYPE_EX.
    - addi, andi, lui go to IMM_EX.
    - beq/bne go to BRANCH.
    - j goes to JUMP.
    - jr goes to JR.
    - jal goes to JAL.
    - {0,0} (nop) goes to FETCH.
    - Anything else goes to ILLEGAL.
  - MEMADR(2): SrcA=1, SrcB=2, ext=1, add. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD(3): memRead=1, iorD=1. Go to MEMWB when ready.
  - MEMWB(4): regDst=0, memToReg=1, regWrite=1. Go to FETCH.
  - MEMWR(5): memWrite=1, iorD=1. Go to FETCH when ready.
  - RTYPE_EX(6): SrcA=1, SrcB=0, ALU code from func. Go to RTYPE_WB.
  - RTYPE_WB(7): regDst=1, memToReg=0, regWrite=1. Go to FETCH.
  - IMM_EX(8): SrcA=1, SrcB=2.
    - addi: ext=1, add.
    - andi: ext=0, and.
    - lui: ext=0, 1111.
    - Go to IMM_WB.
  - IMM_WB(9): regDst=0, regWrite=1. Go to FETCH.
  - BRANCH(10): SrcA=1, SrcB=0, sub, pcSource=1. pcEn = (beq&zero_in)|(bne&~zero_in). Go to FETCH.
  - JUMP(11): pcSource=2, pcEn=1. Go to FETCH.
  - JR(12): pcSource=3, pcEn=1. Go to FETCH.
  - JAL(13): pcSource=2, pcEn=1, regDst=2, memToReg=2, regWrite=1. $ra gets PC (already PC+4) in the same edge the PC loads the target. Go to FETCH.
  - ILLEGAL(14): all strobes 0. Stays until reset. err_out latched on entry.
- Latency in cycles: nop 2, branch/jump/jr/jal 3, R-type and immediate ops 4, sw 4, lw 5. Add one cycle per memory wait cycle.
- Memory wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready_in=0.
  - Clears on ready or on leaving the state.
  - Reaching WAIT_LIMIT goes to ILLEGAL with err=2.
  - If mem_ready_in is high in the cycle the count would hit the limit, ready wins.
- instr_count_out increments on every transition into FETCH from a non-FETCH state. It wraps from 2^COUNT_W-1 to 0. It does not count in ILLEGAL.
- Opcode and func inputs are sampled only in DECODE and the states after it. The IR is stable there.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit encodings above);
  - ALU codes;
  - opcode/func constants (0x0, 0x2, 0x3, 0x4, 0x5, 0x8, 0xc, 0xf, 0x23, 0x2b; func 0x00, 0x08, 0x20, 0x22, 0x27, 0x2a);
  - pcSource, regDst, memToReg and ALUSrcB select codes;
  - err codes.
- One combinational sub-module, mips_alu_decode: op/func to ALU code and ext control. It is used by RTYPE_EX and IMM_EX.

Test Plan:
- Reset with mem_ready_in=1, feed op=0x8 (addi) -> states 0,1,8,9,0; regWrite only in IMM_WB; ALUCntrl=0010, ext=1 in IMM_EX; instr_count=1.
- lw (op 0x23) with mem_ready_in low 3 cycles in MEMRD -> MEMRD held 4 cycles, memRead=1, iorD=1; MEMWB memToReg=1; total 8 cycles.
- beq zero_in=1 -> pcEn=1 in BRANCH, pcSource=1. bne zero_in=1 -> pcEn=0. bne zero_in=0 -> pcEn=1.
- jal (op 0x3) -> JAL state: pcEn=1, pcSource=2, regDst=2, memToReg=2, regWrite=1. jr (0/0x08) -> pcSource=3.
- op=0x3f -> ILLEGAL, err_out=1, all strobes 0 for 20+ cycles. Deassert-assert rst_n_in mid-cycle -> immediate FETCH, err_out=0.
- mem_ready_in held 0 in FETCH with WAIT_LIMIT=4 -> ILLEGAL after 4 cycles, err_out=2. With COUNT_W=2, retire 5 nops -> instr_count 1,2,3,0,1.
